fetch_unit: RTL



---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_pc_reg.sv | 39 +++
 rtl/fetch_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the multicycle RISC-V core front end.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned FAULT_MISALIGN = 0;
  localparam int unsigned FAULT_TIMEOUT  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection and branch-target alignment check.
module fetch_pc_reg
  import riscv_pkg::*;
#(
  parameter int unsigned           XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]       RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wb_en,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc,
  output logic            misalign
);

  logic [XLEN-1:0] pc_next;

  always_comb begin
    misalign = wb_en && branch_taken && (branch_target[1:0] != 2'b00);
    pc_next  = pc;
    if (wb_en) begin
      if (!branch_taken) begin
        pc_next = pc + XLEN'(4);
      end else if (!misalign) begin
        pc_next = branch_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: IF-triggered req/ack memory read, WB-triggered PC advance.
// Define FETCH_TIMEOUT_EN to enable the BUSY watchdog that aborts a fetch after TIMEOUT_CYCLES.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN           = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int unsigned     TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_en,
  input  logic            wb_en,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic            stall,
  output logic [1:0]      fault
);

  fetch_state_t    state, state_next;
  logic            req_next, valid_next, misalign, tmo_hit;
  logic [XLEN-1:0] addr_next;
  logic [31:0]     instr_next;
  logic [1:0]      fault_next;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .reset_n       (reset_n),
    .wb_en         (wb_en),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .misalign      (misalign)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_next;

  always_comb begin
    tmo_cnt_next = tmo_cnt;
    if (state == IDLE && if_en) begin
      tmo_cnt_next = '0;
    end else if (state == BUSY && !imem_ack) begin
      tmo_cnt_next = tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt_next;
    end
  end

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog absent: BUSY waits indefinitely, parameter kept so instantiations stay unchanged.
  localparam bit TMO_ENABLED = 1'b0 && (TIMEOUT_CYCLES != 0);
  assign tmo_hit = TMO_ENABLED;
`endif

  assign stall = (state == BUSY);

  always_comb begin
    state_next = state;
    req_next   = imem_req;
    addr_next  = imem_addr;
    instr_next = instr;
    valid_next = instr_valid;
    fault_next = fault;
    if (misalign) begin
      fault_next[FAULT_MISALIGN] = 1'b1;
    end
    unique case (state)
      IDLE: begin
        if (if_en) begin
          req_next   = 1'b1;
          addr_next  = pc;
          valid_next = 1'b0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // ack takes priority over a coincident timeout
        if (imem_ack) begin
          instr_next = imem_rdata;
          valid_next = 1'b1;
          req_next   = 1'b0;
          state_next = IDLE;
        end else if (tmo_hit) begin
          instr_next = NOP_INSTR;
          valid_next = 1'b1;
          req_next   = 1'b0;
          fault_next[FAULT_TIMEOUT] = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      fault       <= '0;
    end else begin
      state       <= state_next;
      imem_req    <= req_next;
      imem_addr   <= addr_next;
      instr       <= instr_next;
      instr_valid <= valid_next;
      fault       <= fault_next;
    end
  end

endmodule
